// File: rtl/fir_frame_sequencer.sv
// Frame sequencer for the fir filter: feeds frame_len source samples, appends TAPS-1 flush
// zeros, then counts filter outputs until the full convolution has been forwarded.
module fir_frame_sequencer #(
   parameter int unsigned TAPS          = 101,
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned LEN_W         = 20,
   parameter int unsigned DRAIN_TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  frame_len_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   input  logic              src_valid_i,
   input  logic [DATA_W-1:0] src_data_i,
   output logic              src_ready_o,
   output logic              fir_in_valid_o,
   output logic [DATA_W-1:0] fir_in_sample_o,
   input  logic              fir_out_valid_i,
   input  logic [DATA_W-1:0] fir_out_sample_i,
   output logic              snk_valid_o,
   output logic [DATA_W-1:0] snk_data_o
);

   localparam int unsigned IdleW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [LEN_W:0]   FlushLen  = (LEN_W + 1)'(TAPS - 1);
   localparam logic [LEN_W-1:0] FlushLast = (TAPS > 1) ? LEN_W'(TAPS - 2) : '0;
   localparam logic [IdleW-1:0] IdleLast  = IdleW'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StFeed, StFlush, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   in_cnt_q, in_cnt_d;
   logic [LEN_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [LEN_W:0]     out_cnt_q, out_cnt_d;
   logic [LEN_W:0]     out_tgt_q, out_tgt_d;
   logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
   logic               err_q, err_d;
   logic               fir_in_valid_q, fir_in_valid_d;
   logic [DATA_W-1:0]  fir_in_sample_q, fir_in_sample_d;
   logic               snk_valid_q, snk_valid_d;
   logic [DATA_W-1:0]  snk_data_q, snk_data_d;

   logic busy, src_hs, last_in, out_fwd, start_acc, drain_done, timeout;

   assign busy       = (state_q == StFeed) || (state_q == StFlush) || (state_q == StDrain);
   assign src_hs     = (state_q == StFeed) && src_valid_i;
   assign last_in    = (in_cnt_q + LEN_W'(1)) == len_q;
   assign out_fwd    = busy && fir_out_valid_i;
   assign start_acc  = (state_q == StIdle) && start_i && !abort_i;
   assign drain_done = out_cnt_d == out_tgt_q;
   assign timeout    = !fir_out_valid_i && (idle_cnt_q == IdleLast) && !drain_done;

   // Output count saturates at the target so a chatty filter cannot wrap it.
   always_comb begin
      out_cnt_d = out_cnt_q;
      if (start_acc) begin
         out_cnt_d = '0;
      end else if (out_fwd && (out_cnt_q != out_tgt_q)) begin
         out_cnt_d = out_cnt_q + (LEN_W + 1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = (frame_len_i == '0) ? StDone : StFeed;
         StFeed:  if (src_hs && last_in) state_d = (TAPS > 1) ? StFlush : StDrain;
         StFlush: if (flush_cnt_q == FlushLast) state_d = StDrain;
         StDrain: if (drain_done || timeout) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort_i) state_d = StIdle;
   end

   always_comb begin
      busy_o      = busy;
      done_o      = (state_q == StDone);
      src_ready_o = (state_q == StFeed);
   end

   always_comb begin
      len_d           = len_q;
      in_cnt_d        = in_cnt_q;
      flush_cnt_d     = flush_cnt_q;
      out_tgt_d       = out_tgt_q;
      idle_cnt_d      = idle_cnt_q;
      err_d           = err_q;
      fir_in_valid_d  = 1'b0;
      fir_in_sample_d = fir_in_sample_q;
      snk_valid_d     = out_fwd;
      snk_data_d      = out_fwd ? fir_out_sample_i : snk_data_q;
      unique case (state_q)
         StIdle: begin
            if (start_acc) begin
               len_d       = frame_len_i;
               out_tgt_d   = {1'b0, frame_len_i} + FlushLen;
               in_cnt_d    = '0;
               flush_cnt_d = '0;
               idle_cnt_d  = '0;
               err_d       = 1'b0;
            end
         end
         StFeed: begin
            if (src_hs) begin
               fir_in_valid_d  = 1'b1;
               fir_in_sample_d = src_data_i;
               in_cnt_d        = in_cnt_q + LEN_W'(1);
            end
         end
         StFlush: begin
            fir_in_valid_d  = 1'b1;
            fir_in_sample_d = '0;
            flush_cnt_d     = flush_cnt_q + LEN_W'(1);
         end
         StDrain: begin
            if (fir_out_valid_i) idle_cnt_d = '0;
            else if (timeout)    err_d      = 1'b1;
            else                 idle_cnt_d = idle_cnt_q + IdleW'(1);
         end
         default: ;
      endcase
      if (abort_i) begin
         fir_in_valid_d = 1'b0;
         snk_valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q           <= '0;
         in_cnt_q        <= '0;
         flush_cnt_q     <= '0;
         out_cnt_q       <= '0;
         out_tgt_q       <= '0;
         idle_cnt_q      <= '0;
         err_q           <= 1'b0;
         fir_in_valid_q  <= 1'b0;
         fir_in_sample_q <= '0;
         snk_valid_q     <= 1'b0;
         snk_data_q      <= '0;
      end else begin
         len_q           <= len_d;
         in_cnt_q        <= in_cnt_d;
         flush_cnt_q     <= flush_cnt_d;
         out_cnt_q       <= out_cnt_d;
         out_tgt_q       <= out_tgt_d;
         idle_cnt_q      <= idle_cnt_d;
         err_q           <= err_d;
         fir_in_valid_q  <= fir_in_valid_d;
         fir_in_sample_q <= fir_in_sample_d;
         snk_valid_q     <= snk_valid_d;
         snk_data_q      <= snk_data_d;
      end
   end

   assign err_o           = err_q;
   assign fir_in_valid_o  = fir_in_valid_q;
   assign fir_in_sample_o = fir_in_sample_q;
   assign snk_valid_o     = snk_valid_q;
   assign snk_data_o      = snk_data_q;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Scoreboard bench for fir_frame_sequencer with a two-tap (y = x[n] + x[n-1]) latency-3 fir model.
module tb_fir_frame_sequencer;

   localparam int TAPS = 5;
   localparam int DATA_W = 16;
   localparam int LEN_W = 20;
   localparam int DT = 64;

   logic clk = 1'b0, rst_ni = 1'b0, start = 1'b0, abort = 1'b0, src_valid = 1'b0;
   logic [LEN_W-1:0]  frame_len = '0;
   logic [DATA_W-1:0] src_data = '0;
   logic busy, done, err, src_ready, fir_in_valid, fir_out_valid, snk_valid;
   logic [DATA_W-1:0] fir_in_sample, fir_out_sample, snk_data;

   fir_frame_sequencer #(
      .TAPS(TAPS), .DATA_W(DATA_W), .LEN_W(LEN_W), .DRAIN_TIMEOUT(DT)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .frame_len_i(frame_len), .abort_i(abort),
      .busy_o(busy), .done_o(done), .err_o(err), .src_valid_i(src_valid),
      .src_data_i(src_data), .src_ready_o(src_ready), .fir_in_valid_o(fir_in_valid),
      .fir_in_sample_o(fir_in_sample), .fir_out_valid_i(fir_out_valid),
      .fir_out_sample_i(fir_out_sample), .snk_valid_o(snk_valid), .snk_data_o(snk_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // fir model: y = x[n] + x[n-1], out_valid three cycles after in_valid, optional output cap
   logic fir_clr = 1'b1;
   int   limit = 1000, emit = 0;
   logic [DATA_W-1:0] prev, d1, d2, d3;
   logic v1, v2, v3;
   always @(posedge clk) begin
      if (fir_clr) begin
         prev <= '0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; emit <= 0;
         d1 <= '0; d2 <= '0; d3 <= '0;
      end else begin
         if (fir_in_valid) begin
            d1   <= fir_in_sample + prev;
            prev <= fir_in_sample;
         end
         v1 <= fir_in_valid; v2 <= v1; v3 <= v2;
         d2 <= d1; d3 <= d2;
         if (fir_out_valid) emit <= emit + 1;
      end
   end
   assign fir_out_valid  = v3 && (emit < limit);
   assign fir_out_sample = d3;

   int n_cmp = 0, n_bad = 0;
   int exp_in[$], exp_snk[$];
   int in_seen, in_first, in_last, snk_seen, snk_last, n_done = 0, done_cyc, t_start;
   logic err_at_done, busy_at_done, busy_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) if (rst_ni) begin
      if (fir_in_valid) begin
         if (exp_in.size() == 0) check("fir_in_unexpected", 32'(fir_in_sample), 32'hdead);
         else check("fir_in_sample", 32'(fir_in_sample), 32'(exp_in.pop_front()));
         if (in_seen == 0) in_first = cyc;
         in_last = cyc;
         in_seen++;
      end
      if (snk_valid) begin
         if (exp_snk.size() == 0) check("snk_unexpected", 32'(snk_data), 32'hdead);
         else check("snk_data", 32'(snk_data), 32'(exp_snk.pop_front()));
         snk_last = cyc;
         snk_seen++;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin
         n_done++;
         done_cyc     = cyc;
         err_at_done  = err;
         busy_at_done = busy;
      end
   end

   task automatic clear_stats();
      in_seen = 0; in_first = -1; in_last = -1; snk_seen = 0; snk_last = -1;
      busy_seen = 1'b0; done_cyc = -1;
   endtask

   task automatic pulse_fir_clr();
      fir_clr = 1'b1;
      @(negedge clk);
      fir_clr = 1'b0;
   endtask

   task automatic run_source(input int n, input bit bub);
      int idx = 0, guard = 0;
      bit gap = 1'b0, hs;
      while (idx < n && guard < 200 && rst_ni) begin
         src_valid = !(bub && gap);
         src_data  = DATA_W'(idx + 1);
         hs = src_valid && src_ready;
         if (hs) begin idx++; gap = 1'b1; end
         else if (!src_valid) gap = 1'b0;
         guard++;
         @(negedge clk);
      end
      src_valid = 1'b0;
      if (guard >= 200) check("source_timeout", 32'(idx), 32'(n));
   endtask

   task automatic start_frame(input int len);
      frame_len = LEN_W'(len);
      start     = 1'b1;
      t_start   = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n0 = n_done, k = 0;
      while (n_done == n0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(n_done - n0), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_src_ready"}, 32'(src_ready), 0);
      check({tag, "_fir_in_valid"}, 32'(fir_in_valid), 0);
      check({tag, "_fir_in_sample"}, 32'(fir_in_sample), 0);
      check({tag, "_snk_valid"}, 32'(snk_valid), 0);
      check({tag, "_snk_data"}, 32'(snk_data), 0);
   endtask

   task automatic check_queues(input string tag);
      check({tag, "_in_q_left"}, 32'(exp_in.size()), 0);
      check({tag, "_snk_q_left"}, 32'(exp_snk.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nd, z, g, gap;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_ni  = 1'b1;
      fir_clr = 1'b0;
      @(negedge clk);

      // Held source: contiguous 1,2,3,4 then four zeros, latency 2 from start
      clear_stats();
      exp_in  = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_snk = '{1, 3, 5, 7, 4, 0, 0, 0};
      fork
         run_source(4, 1'b0);
         start_frame(4);
      join
      wait_done(100);
      check("t1_in_count", 32'(in_seen), 8);
      check("t1_in_span", 32'(in_last - in_first), 7);
      check("t1_latency", 32'(in_first - t_start), 2);
      check("t1_snk_count", 32'(snk_seen), 8);
      check("t1_done_vs_last_snk", 32'(done_cyc - snk_last), 0);
      check("t1_err", 32'(err_at_done), 0);
      check("t1_busy_at_done", 32'(busy_at_done), 0);
      nd = n_done;
      repeat (3) @(negedge clk);
      check("t1_single_done", 32'(n_done), 32'(nd));
      check_queues("t1");

      // Bubbled source: gaps propagate, zeros follow the last sample directly
      clear_stats();
      exp_in  = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_snk = '{1, 3, 5, 7, 4, 0, 0, 0};
      fork
         run_source(4, 1'b1);
         start_frame(4);
      join
      wait_done(100);
      check("t2_in_count", 32'(in_seen), 8);
      check("t2_in_span", 32'(in_last - in_first), 10);
      check("t2_snk_count", 32'(snk_seen), 8);
      check("t2_err", 32'(err_at_done), 0);
      repeat (2) @(negedge clk);
      check_queues("t2");

      // Zero-length frame
      clear_stats();
      start_frame(0);
      wait_done(10);
      check("t3_done_latency", 32'(done_cyc - t_start), 1);
      check("t3_busy_seen", 32'(busy_seen), 0);
      check("t3_in_count", 32'(in_seen), 0);
      repeat (2) @(negedge clk);

      // Filter stalls after five outputs: drain timeout sets err
      pulse_fir_clr();
      limit = 5;
      clear_stats();
      exp_in  = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_snk = '{1, 3, 5, 7, 4};
      fork
         run_source(4, 1'b0);
         start_frame(4);
      join
      wait_done(200);
      gap = done_cyc - snk_last;
      check("t4_err_at_done", 32'(err_at_done), 1);
      check("t4_timeout_gap", 32'(gap >= DT - 1 && gap <= DT + 2), 1);
      check("t4_snk_count", 32'(snk_seen), 5);
      @(negedge clk);
      check("t4_err_held", 32'(err), 1);
      check_queues("t4");
      limit = 1000;
      pulse_fir_clr();

      // Abort in FLUSH after two zeros; next start clears err
      clear_stats();
      exp_in  = '{1, 2, 3, 4, 0, 0};
      exp_snk = '{1, 3};
      nd = n_done;
      fork
         run_source(4, 1'b0);
         begin
            start_frame(4);
            check("t5_err_cleared", 32'(err), 0);
            z = 0; g = 0;
            while (z < 2 && g < 50) begin
               @(negedge clk);
               if (fir_in_valid && fir_in_sample == 0) z++;
               g++;
            end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("t5_fir_in_low", 32'(fir_in_valid), 0);
            check("t5_busy_low", 32'(busy), 0);
            check("t5_snk_low", 32'(snk_valid), 0);
         end
      join
      repeat (8) @(negedge clk);
      check("t5_no_done", 32'(n_done), 32'(nd));
      check("t5_in_count", 32'(in_seen), 6);
      check_queues("t5");

      // Clean 3-sample frame after the abort
      pulse_fir_clr();
      clear_stats();
      exp_in  = '{1, 2, 3, 0, 0, 0, 0};
      exp_snk = '{1, 3, 5, 3, 0, 0, 0};
      fork
         run_source(3, 1'b0);
         start_frame(3);
      join
      wait_done(100);
      check("t5b_in_count", 32'(in_seen), 7);
      check("t5b_snk_count", 32'(snk_seen), 7);
      check("t5b_done_vs_last_snk", 32'(done_cyc - snk_last), 0);
      repeat (2) @(negedge clk);
      check_queues("t5b");

      // start while busy is ignored: frame still runs at its original length
      pulse_fir_clr();
      clear_stats();
      exp_in  = '{1, 2, 3, 4, 0, 0, 0, 0};
      exp_snk = '{1, 3, 5, 7, 4, 0, 0, 0};
      fork
         run_source(4, 1'b1);
         begin
            start_frame(4);
            repeat (2) @(negedge clk);
            start_frame(2);
         end
      join
      wait_done(100);
      check("t6_in_count", 32'(in_seen), 8);
      check("t6_snk_count", 32'(snk_seen), 8);
      repeat (2) @(negedge clk);
      check_queues("t6");

      // Asynchronous reset mid-FEED
      pulse_fir_clr();
      clear_stats();
      exp_in = '{1, 2};
      nd = n_done;
      fork
         run_source(4, 1'b0);
         begin
            start_frame(4);
            g = 0;
            while (!(fir_in_valid && fir_in_sample == 2) && g < 20) begin
               @(negedge clk);
               g++;
            end
            #2 rst_ni = 1'b0;
            #1 check_outputs_zero("midreset");
         end
      join
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      repeat (6) @(negedge clk);
      check("t7_idle_busy", 32'(busy), 0);
      check("t7_idle_src_ready", 32'(src_ready), 0);
      check("t7_no_done", 32'(n_done), 32'(nd));
      check_queues("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
